// File: rtl/ads127l1x_channel_scheduler.sv
// Streams one captured ADS127L1x frame as a header word followed by one word per
// enabled channel on a 32-bit AXI-Stream; frames arriving mid-drain are dropped and counted.
module ads127l1x_channel_scheduler #(
  parameter int BITS_PER_PACKET = 24,
  parameter int CHANNEL_COUNT   = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     enable,
  input  logic [CHANNEL_COUNT-1:0]                 ch_mask,
  input  logic                                     data_ready,
  input  logic [CHANNEL_COUNT*BITS_PER_PACKET-1:0] ch_packets,
  output logic [31:0]                              m_tdata,
  output logic                                     m_tvalid,
  input  logic                                     m_tready,
  output logic                                     m_tlast,
  output logic                                     busy,
  output logic                                     overrun,
  output logic [15:0]                              overrun_count
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_CHAN = 2'd2} state_t;

  // Returns {found, index} of the lowest set mask bit at or above start.
  function automatic logic [4:0] find_from(input logic [CHANNEL_COUNT-1:0] mask,
                                           input logic [4:0] start);
    logic [4:0] res;
    res = 5'd0;
    for (int k = CHANNEL_COUNT - 1; k >= 0; k--) begin
      if (mask[k] && (5'(k) >= start)) begin
        res = {1'b1, 4'(k)};
      end
    end
    return res;
  endfunction

  function automatic logic [31:0] chan_word(input logic [3:0] idx,
                                            input logic [CHANNEL_COUNT*BITS_PER_PACKET-1:0] pkts);
    logic [23:0] pkt;
    pkt = 24'd0;
    pkt[BITS_PER_PACKET-1:0] = pkts[int'(idx)*BITS_PER_PACKET +: BITS_PER_PACKET];
    return {4'hC, idx, pkt};
  endfunction

  state_t                                 r_state;
  logic                                   r_dr_d;
  logic [15:0]                            r_seq;
  logic [15:0]                            r_sh_seq;
  logic [CHANNEL_COUNT-1:0]               r_sh_mask;
  logic [CHANNEL_COUNT*BITS_PER_PACKET-1:0] r_sh_pkts;
  logic [3:0]                             r_idx;
  logic [31:0]                            r_data;
  logic                                   r_valid;
  logic                                   r_last;
  logic                                   r_busy;
  logic                                   r_overrun;
  logic [15:0]                            r_ovr_cnt;

  logic       w_fe, w_take, w_hs, w_accept, w_drop, w_more;
  logic [4:0] w_start, w_cur, w_after;
  logic [7:0] w_mask8;
  state_t     w_nxt_state;
  logic       w_nxt_valid, w_nxt_last;
  logic [31:0] w_nxt_data;
  logic [3:0] w_nxt_idx;

  assign w_fe     = data_ready & ~r_dr_d;
  assign w_take   = w_fe & enable & (|ch_mask);
  assign w_hs     = r_valid & m_tready;
  // A new frame landing on the closing handshake is accepted rather than dropped.
  assign w_accept = w_take & ((r_state == S_IDLE) | (r_state == S_CHAN & w_hs & r_last));
  assign w_drop   = w_take & ~w_accept;
  assign w_mask8  = 8'(r_sh_mask);

  // Channel walk: current word index and whether another enabled channel follows it.
  always_comb begin
    w_start = 5'd0;
    if (r_state == S_HDR) begin
      w_start = 5'd0;
    end else begin
      w_start = {1'b0, r_idx} + 5'd1;
    end
    w_cur   = find_from(r_sh_mask, w_start);
    w_after = find_from(r_sh_mask, {1'b0, w_cur[3:0]} + 5'd1);
    w_more  = w_after[4];
  end

  // Next-state and output-word selection.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_valid = r_valid;
    w_nxt_data  = r_data;
    w_nxt_last  = r_last;
    w_nxt_idx   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_nxt_state = S_HDR;
        else          w_nxt_state = S_IDLE;
      end
      S_HDR: begin
        if (!r_valid) begin
          w_nxt_valid = 1'b1;
          w_nxt_data  = {8'hA5, w_mask8, r_sh_seq};
          w_nxt_last  = 1'b0;
        end else if (w_hs) begin
          w_nxt_state = S_CHAN;
          w_nxt_idx   = w_cur[3:0];
          w_nxt_data  = chan_word(w_cur[3:0], r_sh_pkts);
          w_nxt_last  = ~w_more;
        end else begin
          w_nxt_state = S_HDR;
        end
      end
      S_CHAN: begin
        if (w_hs && r_last) begin
          w_nxt_valid = 1'b0;
          w_nxt_last  = 1'b0;
          w_nxt_data  = 32'd0;
          w_nxt_state = w_accept ? S_HDR : S_IDLE;
        end else if (w_hs) begin
          w_nxt_idx   = w_cur[3:0];
          w_nxt_data  = chan_word(w_cur[3:0], r_sh_pkts);
          w_nxt_last  = ~w_more;
        end else begin
          w_nxt_state = S_CHAN;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_valid = 1'b0;
        w_nxt_data  = 32'd0;
        w_nxt_last  = 1'b0;
        w_nxt_idx   = 4'd0;
      end
    endcase
  end

  // State, stream output, snapshot and overrun registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_dr_d    <= 1'b0;
      r_seq     <= 16'd0;
      r_sh_seq  <= 16'd0;
      r_sh_mask <= '0;
      r_sh_pkts <= '0;
      r_idx     <= 4'd0;
      r_data    <= 32'd0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      r_ovr_cnt <= 16'd0;
    end else begin
      r_state   <= w_nxt_state;
      r_dr_d    <= data_ready;
      r_idx     <= w_nxt_idx;
      r_data    <= w_nxt_data;
      r_valid   <= w_nxt_valid;
      r_last    <= w_nxt_last;
      r_busy    <= (w_nxt_state != S_IDLE);
      r_overrun <= w_drop;
      if (w_take) begin
        r_seq <= r_seq + 16'd1;
      end else begin
        r_seq <= r_seq;
      end
      if (w_accept) begin
        r_sh_seq  <= r_seq;
        r_sh_mask <= ch_mask;
        r_sh_pkts <= ch_packets;
      end else begin
        r_sh_seq  <= r_sh_seq;
        r_sh_mask <= r_sh_mask;
        r_sh_pkts <= r_sh_pkts;
      end
      if (w_drop && (r_ovr_cnt != 16'hFFFF)) begin
        r_ovr_cnt <= r_ovr_cnt + 16'd1;
      end else begin
        r_ovr_cnt <= r_ovr_cnt;
      end
    end
  end

  assign m_tdata       = r_data;
  assign m_tvalid      = r_valid;
  assign m_tlast       = r_last;
  assign busy          = r_busy;
  assign overrun       = r_overrun;
  assign overrun_count = r_ovr_cnt;

endmodule

// File: tb/tb_ads127l1x_channel_scheduler.sv
// Scoreboard bench: stimulus pushes expected {tlast, tdata} words, a negedge monitor pops
// and compares them on every handshake, plus directed checks of status outputs.
module tb_ads127l1x_channel_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  ch_mask = 8'd0;
  logic        data_ready = 1'b0;
  logic [191:0] ch_packets = '0;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic        busy;
  logic        overrun;
  logic [15:0] overrun_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = 32'd0;

  ads127l1x_channel_scheduler #(.BITS_PER_PACKET(24), .CHANNEL_COUNT(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask),
    .data_ready(data_ready), .ch_packets(ch_packets),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .overrun(overrun), .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fe_pulse();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    tick();
  endtask

  task automatic push_hdr(input logic [7:0] mask, input logic [15:0] seq);
    exp_q.push_back({1'b0, 8'hA5, mask, seq});
  endtask

  task automatic push_frame(input logic [7:0] mask, input logic [15:0] seq);
    int top;
    top = 0;
    for (int k = 0; k < 8; k++) if (mask[k]) top = k;
    push_hdr(mask, seq);
    for (int k = 0; k < 8; k++) begin
      if (mask[k]) exp_q.push_back({(k == top), 4'hC, 4'(k), 24'h100000 + 24'(k)});
    end
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50 && !m_tvalid; i++) tick();
    check("valid_timeout", {32'd0, m_tvalid}, 33'd1);
  endtask

  task automatic wait_last();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (m_tvalid && m_tready && m_tlast) seen = 1'b1;
    end
    check("last_seen", {32'd0, seen}, 33'd1);
    tick();
  endtask

  // Scoreboard monitor: compares each transferred word and holds data stable across stalls.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", {32'd0, m_tvalid}, 33'd1);
          check("stall_data", {1'b0, m_tdata}, {1'b0, prev_data});
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_word: got %h expected none", m_tdata);
          end else begin
            e = exp_q.pop_front();
            check("tdata", {1'b0, m_tdata}, {1'b0, e[31:0]});
            check("tlast", {32'd0, m_tlast}, {32'd0, e[32]});
          end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 8; k++) ch_packets[k*24 +: 24] = 24'h100000 + 24'(k);
    repeat (3) tick();
    check("rst_valid", {32'd0, m_tvalid}, 33'd0);
    check("rst_data", {1'b0, m_tdata}, 33'd0);
    check("rst_busy", {32'd0, busy}, 33'd0);
    check("rst_overrun", {32'd0, overrun}, 33'd0);
    check("rst_count", {17'd0, overrun_count}, 33'd0);
    rst_n = 1'b1;
    enable = 1'b1;
    tick();

    // 1: full mask, back-to-back words
    ch_mask = 8'hFF;
    m_tready = 1'b1;
    push_frame(8'hFF, 16'd0);
    fe_pulse();
    wait_valid();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("no_bubble", {32'd0, m_tvalid}, 33'd1);
    end
    tick();

    // 2: sparse mask, busy drops after the last word
    ch_mask = 8'h81;
    push_frame(8'h81, 16'd1);
    fe_pulse();
    wait_last();
    check("busy_after", {32'd0, busy}, 33'd0);

    // 3: header held under backpressure
    ch_mask = 8'hFF;
    m_tready = 1'b0;
    push_frame(8'hFF, 16'd2);
    fe_pulse();
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {32'd0, m_tvalid}, 33'd1);
      check("hold_data", {1'b0, m_tdata}, {1'b0, 32'hA5FF0002});
      tick();
    end
    m_tready = 1'b1;
    wait_last();

    // 4: overrun while a channel word is stalled
    m_tready = 1'b0;
    push_frame(8'hFF, 16'd3);
    fe_pulse();
    wait_valid();
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    data_ready = 1'b1;
    tick();
    check("ovr_pulse", {32'd0, overrun}, 33'd1);
    check("ovr_count", {17'd0, overrun_count}, 33'd1);
    data_ready = 1'b0;
    tick();
    check("ovr_single", {32'd0, overrun}, 33'd0);
    m_tready = 1'b1;
    wait_last();
    ch_mask = 8'h81;
    push_frame(8'h81, 16'd5);
    fe_pulse();
    wait_last();

    // 5: new frame on the closing handshake
    push_frame(8'h81, 16'd6);
    push_frame(8'h81, 16'd7);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    for (int i = 0; i < 50 && !(m_tvalid && m_tlast); i++) @(negedge clk);
    data_ready = 1'b1;
    tick();
    check("b2b_no_ovr", {32'd0, overrun}, 33'd0);
    check("b2b_busy", {32'd0, busy}, 33'd1);
    data_ready = 1'b0;
    tick();
    check("b2b_hdr_valid", {32'd0, m_tvalid}, 33'd1);
    wait_last();
    check("b2b_count", {17'd0, overrun_count}, 33'd1);

    // 6: reset mid-frame
    ch_mask = 8'hFF;
    m_tready = 1'b0;
    push_hdr(8'hFF, 16'd8);
    fe_pulse();
    wait_valid();
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {32'd0, m_tvalid}, 33'd0);
    check("arst_busy", {32'd0, busy}, 33'd0);
    check("arst_count", {17'd0, overrun_count}, 33'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    ch_mask = 8'h81;
    m_tready = 1'b1;
    push_frame(8'h81, 16'd0);
    fe_pulse();
    wait_last();

    // 7: ignored frame events
    enable = 1'b0;
    data_ready = 1'b1;
    tick();
    check("dis_overrun", {32'd0, overrun}, 33'd0);
    check("dis_busy", {32'd0, busy}, 33'd0);
    data_ready = 1'b0;
    tick();
    check("dis_valid", {32'd0, m_tvalid}, 33'd0);
    enable = 1'b1;
    ch_mask = 8'h00;
    data_ready = 1'b1;
    tick();
    check("mask0_overrun", {32'd0, overrun}, 33'd0);
    check("mask0_busy", {32'd0, busy}, 33'd0);
    data_ready = 1'b0;
    tick();
    check("mask0_valid", {32'd0, m_tvalid}, 33'd0);
    ch_mask = 8'h81;
    push_frame(8'h81, 16'd1);
    fe_pulse();
    wait_last();

    repeat (5) tick();
    check("queue_empty", 33'(exp_q.size()), 33'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
